// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with a saturating
// direction counter per entry.
// The fetch side gets a combinational prediction from the registered table.
// The decode side trains the table, flags mispredictions and keeps
// branch/misprediction statistics.
//
// Update strobe: upd_valid_i is a single-cycle qualifier with no back-pressure.
// Every cycle it is high (and start_i is high), the upd_* bundle is consumed
// at the next rising edge. mispredict_o and redirect_pc_o describe that same
// bundle combinationally during the cycle.
module branch_predictor #(
  parameter int          ENTRIES   = 16,
  parameter int          ADDR_W    = 32,
  parameter int          CNT_W     = 2,
  // Value both statistics counters take on reset; 0 for normal operation.
  parameter logic [31:0] STAT_INIT = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  // fetch-side lookup
  input  logic [ADDR_W-1:0] if_pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  // decode-side resolution
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  output logic              mispredict_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
  // statistics
  output logic [31:0]       branch_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  // Counter encodings: MSB set means "predict taken".
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MIN = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  // ---------------------------------------------------------------------------
  // Address split
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;

  assign if_idx  = if_pc_i[IDX_W+1:2];
  assign if_tag  = if_pc_i[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];

  // Instructions are word aligned; the byte offset never selects anything.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{if_pc_i[1:0], upd_pc_i[1:0]};

  // ---------------------------------------------------------------------------
  // Lookup path
  // ---------------------------------------------------------------------------
  logic              if_hit;
  logic              if_taken;
  logic [ADDR_W-1:0] if_seq_pc;

  // Combinational lookup against the registered table; no bypass from the
  // update port, so a same-cycle update is seen only from the next cycle.
  always_comb begin
    if_seq_pc     = if_pc_i + PC_STEP;
    if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    if_taken      = start_i && if_hit && cnt_q[if_idx][CNT_W-1];
    pred_taken_o  = if_taken;
    pred_target_o = if_taken ? target_q[if_idx] : if_seq_pc;
  end

  // ---------------------------------------------------------------------------
  // Resolution: misprediction and redirect
  // ---------------------------------------------------------------------------
  logic train;
  logic dir_wrong;
  logic tgt_wrong;

  // Wrong direction, or right "taken" direction but to a stale target.
  always_comb begin
    train         = upd_valid_i && start_i;
    dir_wrong     = (upd_pred_taken_i != upd_taken_i);
    tgt_wrong     = upd_taken_i && (upd_pred_target_i != upd_target_i);
    mispredict_o  = train && (dir_wrong || tgt_wrong);
    redirect_pc_o = upd_taken_i ? upd_target_i : (upd_pc_i + PC_STEP);
  end

  // ---------------------------------------------------------------------------
  // Training: compute the next contents of the single entry being touched
  // ---------------------------------------------------------------------------
  logic              upd_hit;
  logic [CNT_W-1:0]  upd_cnt_cur;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  cnt_dec;
  logic              entry_we;
  logic              entry_valid_d;
  logic [TAG_W-1:0]  entry_tag_d;
  logic [ADDR_W-1:0] entry_target_d;
  logic [CNT_W-1:0]  entry_cnt_d;

  // Saturating counter arithmetic for the addressed entry.
  always_comb begin
    upd_cnt_cur = cnt_q[upd_idx];
    cnt_inc     = (upd_cnt_cur == CNT_MAX) ? CNT_MAX : upd_cnt_cur + CNT_W'(1);
    cnt_dec     = (upd_cnt_cur == CNT_MIN) ? CNT_MIN : upd_cnt_cur - CNT_W'(1);
  end

  // Decide hit-train, allocate, or leave alone; a not-taken miss never
  // allocates so cold not-taken branches do not evict useful entries.
  always_comb begin
    upd_hit        = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    entry_we       = 1'b0;
    entry_valid_d  = valid_q[upd_idx];
    entry_tag_d    = tag_q[upd_idx];
    entry_target_d = target_q[upd_idx];
    entry_cnt_d    = upd_cnt_cur;
    if (train) begin
      if (upd_hit) begin
        entry_we = 1'b1;
        if (upd_taken_i) begin
          entry_cnt_d    = cnt_inc;
          entry_target_d = upd_target_i;
        end else begin
          entry_cnt_d    = cnt_dec;
        end
      end else if (upd_taken_i) begin
        entry_we       = 1'b1;
        entry_valid_d  = 1'b1;
        entry_tag_d    = upd_tag;
        entry_target_d = upd_target_i;
        entry_cnt_d    = CNT_WT;
      end
    end
  end

  // Table register: reset wipes every entry and wins over a same-edge update.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (entry_we) begin
      valid_q[upd_idx]  <= entry_valid_d;
      tag_q[upd_idx]    <= entry_tag_d;
      target_q[upd_idx] <= entry_target_d;
      cnt_q[upd_idx]    <= entry_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] miss_cnt_q,   miss_cnt_d;

  // Free-running 32-bit event counters; wrap naturally at 2^32.
  always_comb begin
    branch_cnt_d = branch_cnt_q + {31'b0, train};
    miss_cnt_d   = miss_cnt_q   + {31'b0, mispredict_o};
  end

  // Statistics registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q <= STAT_INIT;
      miss_cnt_q   <= STAT_INIT;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign branch_cnt_o = branch_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, allocation, counter hysteresis,
// aliasing, corner cases, mid-run reset and statistics wrap-around.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] if_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  // second instance with preset statistics for the wrap check
  logic        w_rst;
  logic        w_upd_valid;
  logic        w_pred_taken;
  logic [31:0] w_pred_target;
  logic        w_mispredict;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_branch_cnt;
  logic [31:0] w_miss_cnt;

  int total = 0;
  int bad   = 0;

  branch_predictor #(.ENTRIES(16), .ADDR_W(32), .CNT_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .if_pc_i(if_pc), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target),
    .mispredict_o(mispredict), .redirect_pc_o(redirect_pc),
    .branch_cnt_o(branch_cnt), .miss_cnt_o(miss_cnt)
  );

  branch_predictor #(.ENTRIES(16), .ADDR_W(32), .CNT_W(2),
                     .STAT_INIT(32'hFFFF_FFFE)) dut_w (
    .clk_i(clk), .rst_i(w_rst), .start_i(start),
    .if_pc_i(if_pc), .pred_taken_o(w_pred_taken), .pred_target_o(w_pred_target),
    .upd_valid_i(w_upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_pred_taken_i(upd_pred_taken),
    .upd_pred_target_i(upd_pred_target),
    .mispredict_o(w_mispredict), .redirect_pc_o(w_redirect_pc),
    .branch_cnt_o(w_branch_cnt), .miss_cnt_o(w_miss_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic taken,
                           input logic [31:0] target, input logic ptaken,
                           input logic [31:0] ptarget);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = taken;
    upd_target      = target;
    upd_pred_taken  = ptaken;
    upd_pred_target = ptarget;
    #1;
  endtask

  task automatic idle_upd();
    upd_valid = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag, input logic [31:0] eb,
                             input logic [31:0] em);
    check({tag, "_branch_cnt"}, branch_cnt, eb);
    check({tag, "_miss_cnt"}, miss_cnt, em);
  endtask

  task automatic check_look(input string tag, input logic [31:0] pc,
                            input logic et, input logic [31:0] etgt);
    look(pc);
    check({tag, "_pred_taken"}, {31'b0, pred_taken}, {31'b0, et});
    check({tag, "_pred_target"}, pred_target, etgt);
  endtask

  task automatic check_res(input string tag, input logic em,
                           input logic [31:0] ered);
    check({tag, "_mispredict"}, {31'b0, mispredict}, {31'b0, em});
    check({tag, "_redirect"}, redirect_pc, ered);
  endtask

  // ---------------------------------------------------------------------------
  // directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; w_rst = 1'b1; start = 1'b1;
    if_pc = 32'h0; upd_valid = 1'b0; w_upd_valid = 1'b0;
    upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    tick(); tick();
    rst = 1'b0; w_rst = 1'b0;

    // reset state
    check_look("reset_look", 32'h40, 1'b0, 32'h44);
    check_stats("reset", 32'd0, 32'd0);

    // allocation: cnt -> 2
    drive_upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h44);
    check_res("alloc", 1'b1, 32'h20);
    tick(); idle_upd();
    check_look("alloc_look", 32'h40, 1'b1, 32'h20);
    check_stats("alloc", 32'd1, 32'd1);

    // hysteresis: NT -> cnt 1
    drive_upd(32'h40, 1'b0, 32'h20, 1'b1, 32'h20);
    check_res("hy_nt1", 1'b1, 32'h44);
    tick(); idle_upd();
    check_look("hy_nt1_look", 32'h40, 1'b0, 32'h44);
    check_stats("hy_nt1", 32'd2, 32'd2);

    // T -> cnt 2 (predicted NT: mispredict)
    drive_upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h44);
    check_res("hy_t1", 1'b1, 32'h20);
    tick(); idle_upd();
    check_look("hy_t1_look", 32'h40, 1'b1, 32'h20);
    check_stats("hy_t1", 32'd3, 32'd3);

    // T -> cnt 3 (predicted correctly)
    drive_upd(32'h40, 1'b1, 32'h20, 1'b1, 32'h20);
    check_res("hy_t2", 1'b0, 32'h20);
    tick(); idle_upd();
    check_stats("hy_t2", 32'd4, 32'd3);

    // T with new target -> cnt stays 3, target mismatch is a mispredict
    drive_upd(32'h40, 1'b1, 32'h30, 1'b1, 32'h20);
    check_res("hy_t3", 1'b1, 32'h30);
    tick(); idle_upd();
    check_look("hy_t3_look", 32'h40, 1'b1, 32'h30);
    check_stats("hy_t3", 32'd5, 32'd4);

    // one NT from saturation -> cnt 2, still taken
    drive_upd(32'h40, 1'b0, 32'h30, 1'b1, 32'h30);
    check_res("hy_nt2", 1'b1, 32'h44);
    tick(); idle_upd();
    check_look("hy_nt2_look", 32'h40, 1'b1, 32'h30);
    check_stats("hy_nt2", 32'd6, 32'd5);

    // aliasing: 0x80 shares index 0 with 0x40
    check_look("alias_miss", 32'h80, 1'b0, 32'h84);
    drive_upd(32'h80, 1'b1, 32'h100, 1'b0, 32'h84);
    check_res("alias_upd", 1'b1, 32'h100);
    tick(); idle_upd();
    check_look("alias_old", 32'h40, 1'b0, 32'h44);
    check_look("alias_new", 32'h80, 1'b1, 32'h100);
    check_stats("alias", 32'd7, 32'd6);

    // not-taken update to empty index 1 does not allocate
    drive_upd(32'h44, 1'b0, 32'h400, 1'b0, 32'h48);
    check_res("nt_empty", 1'b0, 32'h48);
    tick(); idle_upd();
    check_look("nt_empty_look", 32'h44, 1'b0, 32'h48);
    check_stats("nt_empty", 32'd8, 32'd6);

    // start_i low: no prediction, no mispredict, no training, no stats
    start = 1'b0;
    look(32'h80);
    drive_upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
    check("nostart_pred_taken", {31'b0, pred_taken}, 32'd0);
    check("nostart_pred_target", pred_target, 32'h84);
    check_res("nostart", 1'b0, 32'h200);
    tick(); idle_upd();
    start = 1'b1;
    check_look("nostart_look", 32'h80, 1'b1, 32'h100);
    check_stats("nostart", 32'd8, 32'd6);

    // same-cycle lookup and update of index 0: lookup sees old contents
    look(32'h80);
    drive_upd(32'h80, 1'b0, 32'h100, 1'b1, 32'h100);
    check("same_pred_taken", {31'b0, pred_taken}, 32'd1);
    check("same_pred_target", pred_target, 32'h100);
    check_res("same", 1'b1, 32'h84);
    tick(); idle_upd();
    check_look("same_after", 32'h80, 1'b0, 32'h84);
    check_stats("same", 32'd9, 32'd7);

    // reset together with a taken update: reset wins
    rst = 1'b1;
    drive_upd(32'h40, 1'b1, 32'h20, 1'b0, 32'h44);
    tick(); idle_upd();
    rst = 1'b0;
    check_look("rst_mid_40", 32'h40, 1'b0, 32'h44);
    check_look("rst_mid_80", 32'h80, 1'b0, 32'h84);
    check_stats("rst_mid", 32'd0, 32'd0);

    // statistics wrap on the preset instance
    check("wrap0_miss", w_miss_cnt, 32'hFFFF_FFFE);
    upd_valid = 1'b0;
    upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h20;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h44;
    w_upd_valid = 1'b1;
    #1;
    check("wrap_mispredict", {31'b0, w_mispredict}, 32'd1);
    tick();
    check("wrap1_miss", w_miss_cnt, 32'hFFFF_FFFF);
    tick();
    w_upd_valid = 1'b0;
    check("wrap2_miss", w_miss_cnt, 32'h0);
    check("wrap2_branch", w_branch_cnt, 32'h0);
    tick();
    check("wrap3_miss", w_miss_cnt, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
